buzzer_arbiter: RTL and testbench



---
 rtl/buzzer_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_buzzer_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_arbiter.sv
// Shares the single song player between alarm, timer and hourly chime requests:
// fixed priority alarm > timer > chime, each grant sequenced as a play burst then a silent gap.
module buzzer_arbiter #(
    parameter int unsigned ALARM_MAX = 60000,
    parameter int unsigned TIMER_DUR = 10000,
    parameter int unsigned CHIME_DUR = 1000,
    parameter int unsigned GAP_TICKS = 200,
    parameter int unsigned CW        = 16
) (
    input  logic       newclk,
    input  logic       rst,
    input  logic       alarm_req,
    input  logic       timer_req,
    input  logic       chime_req,
    input  logic       chime_en,
    input  logic       ack,
    output logic       play,
    output logic [1:0] song_sel,
    output logic       busy,
    output logic [2:0] pend,
    output logic       done
);

    localparam int unsigned NSRC    = 3;
    localparam int unsigned SW      = 2;
    localparam int unsigned P_ALARM = 0;
    localparam int unsigned P_TIMER = 1;
    localparam int unsigned P_CHIME = 2;

    localparam logic [SW-1:0] SRC_NONE  = SW'(0);
    localparam logic [SW-1:0] SRC_ALARM = SW'(1);
    localparam logic [SW-1:0] SRC_TIMER = SW'(2);
    localparam logic [SW-1:0] SRC_CHIME = SW'(3);

    localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_MAX - 1);
    localparam logic [CW-1:0] TIMER_LAST = CW'(TIMER_DUR - 1);
    localparam logic [CW-1:0] CHIME_LAST = CW'(CHIME_DUR - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_q, next_state;
    logic [CW-1:0]   cnt_q, next_cnt;
    logic [SW-1:0]   src_q, next_src;
    logic [NSRC-1:0] pend_q, next_pend;
    logic [NSRC-1:0] grant;
    logic            burst_end;

    logic            alarm_q, timer_q, chime_q, ack_q;
    logic            hist_vld;
    logic [NSRC-1:0] req_edge;
    logic            ack_edge;
    logic            preempt;
    logic [CW-1:0]   dur_last;

    // Input history; hist_vld masks the first sample after reset so a held request does not fire.
    always_ff @(posedge newclk or posedge rst) begin
        if (rst) begin
            alarm_q  <= 1'b0;
            timer_q  <= 1'b0;
            chime_q  <= 1'b0;
            ack_q    <= 1'b0;
            hist_vld <= 1'b0;
        end else begin
            alarm_q  <= alarm_req;
            timer_q  <= timer_req;
            chime_q  <= chime_req;
            ack_q    <= ack;
            hist_vld <= 1'b1;
        end
    end

    assign req_edge = {NSRC{hist_vld}} & {chime_req & ~chime_q & chime_en,
                                          timer_req & ~timer_q,
                                          alarm_req & ~alarm_q};
    assign ack_edge = hist_vld & ack & ~ack_q;
    assign preempt  = (src_q != SRC_ALARM) && pend_q[P_ALARM];

    // Last counter value of the burst for the granted source.
    always_comb begin
        dur_last = CHIME_LAST;
        case (src_q)
            SRC_ALARM: dur_last = ALARM_LAST;
            SRC_TIMER: dur_last = TIMER_LAST;
            default:   dur_last = CHIME_LAST;
        endcase
    end

    // State, counter, granted source and pending flags.
    always_ff @(posedge newclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= SRC_NONE;
            pend_q  <= '0;
        end else begin
            state_q <= next_state;
            cnt_q   <= next_cnt;
            src_q   <= next_src;
            pend_q  <= next_pend;
        end
    end

    // Next-state logic: grants, burst timeout/ack, alarm preemption and gap timing.
    always_comb begin
        next_state = state_q;
        next_cnt   = cnt_q;
        next_src   = src_q;
        grant      = '0;
        burst_end  = 1'b0;
        unique case (state_q)
            IDLE: begin
                next_cnt = '0;
                if (pend_q[P_ALARM]) begin
                    grant[P_ALARM] = 1'b1;
                    next_src       = SRC_ALARM;
                    next_state     = PLAY;
                end else if (pend_q[P_TIMER]) begin
                    grant[P_TIMER] = 1'b1;
                    next_src       = SRC_TIMER;
                    next_state     = PLAY;
                end else if (pend_q[P_CHIME]) begin
                    grant[P_CHIME] = 1'b1;
                    next_src       = SRC_CHIME;
                    next_state     = PLAY;
                end
            end
            PLAY: begin
                if (preempt) begin
                    grant[P_ALARM] = 1'b1;
                    next_src       = SRC_ALARM;
                    next_cnt       = '0;
                    burst_end      = 1'b1;
                end else if ((cnt_q == dur_last) || ack_edge) begin
                    next_state = GAP;
                    next_cnt   = '0;
                    burst_end  = 1'b1;
                end else begin
                    next_cnt = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt_q + CW'(1);
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
        // A new edge on the bit being granted keeps it pending.
        next_pend = (pend_q & ~grant) | req_edge;
    end

    // Outputs decoded from the state register; done marks the final cycle of a burst.
    always_comb begin
        play     = 1'b0;
        song_sel = SRC_NONE;
        busy     = 1'b0;
        done     = 1'b0;
        pend     = pend_q;
        case (state_q)
            PLAY: begin
                play     = 1'b1;
                song_sel = src_q;
                busy     = 1'b1;
                done     = burst_end;
            end
            GAP: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Bench for buzzer_arbiter: directed scenarios plus a random phase, each cycle
// checked against a countdown-based reference model of the arbitration rules.
module tb_buzzer_arbiter;

    localparam int ALARM_MAX = 60000;
    localparam int TIMER_DUR = 10000;
    localparam int CHIME_DUR = 1000;
    localparam int GAP_TICKS = 200;

    logic       newclk;
    logic       rst;
    logic       alarm_req, timer_req, chime_req, chime_en, ack;
    logic       play;
    logic [1:0] song_sel;
    logic       busy;
    logic [2:0] pend;
    logic       done;

    int errors = 0;
    int checks = 0;

    buzzer_arbiter dut (
        .newclk    (newclk),
        .rst       (rst),
        .alarm_req (alarm_req),
        .timer_req (timer_req),
        .chime_req (chime_req),
        .chime_en  (chime_en),
        .ack       (ack),
        .play      (play),
        .song_sel  (song_sel),
        .busy      (busy),
        .pend      (pend),
        .done      (done)
    );

    initial newclk = 1'b0;
    always #5 newclk = ~newclk;

    // Reference model: remaining play/gap cycles counted down, source as 1..3.
    int       m_play_left, m_gap_left, m_src;
    bit [2:0] m_pend;
    bit       m_pa, m_pt, m_pc, m_pk, m_fresh;

    // Observation bookkeeping.
    int         cyc;
    int         n_play, n_done, n_gap, first_play;
    int         n_sel [4];
    logic       last_play, last_busy;
    logic [1:0] last_sel;
    logic [2:0] last_pend;

    function automatic int dur_of(input int s);
        return (s == 1) ? ALARM_MAX : (s == 2) ? TIMER_DUR : CHIME_DUR;
    endfunction

    task automatic model_reset();
        m_play_left = 0; m_gap_left = 0; m_src = 0; m_pend = 3'b000;
        m_pa = 0; m_pt = 0; m_pc = 0; m_pk = 0; m_fresh = 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
        if (errors >= 40) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    endtask

    task automatic model_expect(output logic [7:0] e);
        bit playing, ack_e, pre, d;
        playing = (m_play_left > 0);
        ack_e   = !m_fresh && ack && !m_pk;
        pre     = playing && (m_src != 1) && m_pend[0];
        d       = playing && ((m_play_left == 1) || ack_e || pre);
        e = {playing, playing ? 2'(m_src) : 2'd0, playing || (m_gap_left > 0), m_pend, d};
    endtask

    task automatic model_advance();
        bit a_e, t_e, c_e, k_e;
        if (rst) begin
            model_reset();
            return;
        end
        a_e = !m_fresh && alarm_req && !m_pa;
        t_e = !m_fresh && timer_req && !m_pt;
        c_e = !m_fresh && chime_req && !m_pc && chime_en;
        k_e = !m_fresh && ack && !m_pk;
        if (m_play_left > 0) begin
            if (m_src != 1 && m_pend[0]) begin
                m_src = 1; m_play_left = ALARM_MAX; m_pend[0] = 0;
            end else if (m_play_left == 1 || k_e) begin
                m_play_left = 0; m_gap_left = GAP_TICKS;
            end else begin
                m_play_left--;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (m_pend != 3'b000) begin
            m_src = m_pend[0] ? 1 : (m_pend[1] ? 2 : 3);
            m_pend[m_src-1] = 0;
            m_play_left = dur_of(m_src);
        end
        if (a_e) m_pend[0] = 1;
        if (t_e) m_pend[1] = 1;
        if (c_e) m_pend[2] = 1;
        m_pa = alarm_req; m_pt = timer_req; m_pc = chime_req; m_pk = ack;
        m_fresh = 0;
    endtask

    task automatic clr_stats();
        n_play = 0; n_done = 0; n_gap = 0; first_play = -1;
        for (int i = 0; i < 4; i++) n_sel[i] = 0;
    endtask

    // One clock: called just after a negedge with inputs already driven.
    task automatic cycle();
        logic [7:0] e, o;
        #1;
        model_expect(e);
        o = {play, song_sel, busy, pend, done};
        check($sformatf("cyc%0d_outputs", cyc), 32'(o), 32'(e));
        if (play === 1'b1) begin
            n_play++;
            if (first_play < 0) first_play = cyc;
        end
        if (done === 1'b1) n_done++;
        if (busy === 1'b1 && play === 1'b0) n_gap++;
        if (!$isunknown(song_sel)) n_sel[song_sel]++;
        last_play = play; last_busy = busy; last_sel = song_sel; last_pend = pend;
        model_advance();
        cyc++;
        @(negedge newclk);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n;
        n = 0;
        do begin cycle(); n++; end while ((last_busy !== 1'b0 || last_pend !== 3'b000) && n < bound);
        check({tag, "_idle_reached"}, 32'(last_busy !== 1'b0 || last_pend !== 3'b000), 32'd0);
    endtask

    task automatic wait_play(input int bound, input string tag);
        int n;
        n = 0;
        do begin cycle(); n++; end while (last_play !== 1'b1 && n < bound);
        check({tag, "_play_seen"}, 32'(last_play), 32'd1);
    endtask

    initial begin
        int t0, k, n;
        rst = 1'b1; alarm_req = 0; timer_req = 0; chime_req = 0; chime_en = 1; ack = 0;
        cyc = 0;
        model_reset();
        clr_stats();
        @(negedge newclk);
        cycle();
        cycle();
        check("reset_outputs", 32'({play, song_sel, busy, pend, done}), 32'd0);
        rst = 1'b0;
        repeat (8) cycle();

        // 1: timer pulse -> 10000-cycle burst two cycles later, then 200-cycle gap.
        clr_stats();
        t0 = cyc;
        timer_req = 1; cycle(); timer_req = 0;
        wait_idle(12000, "t1");
        check("t1_first_play", 32'(first_play), 32'(t0 + 2));
        check("t1_play_len", 32'(n_play), 32'(TIMER_DUR));
        check("t1_sel_timer", 32'(n_sel[2]), 32'(TIMER_DUR));
        check("t1_done_count", 32'(n_done), 32'd1);
        check("t1_gap_len", 32'(n_gap), 32'(GAP_TICKS));

        // 2: held alarm stopped by ack after 500 play cycles.
        clr_stats();
        alarm_req = 1;
        wait_play(10, "t2");
        repeat (499) cycle();
        ack = 1; cycle(); ack = 0;
        wait_idle(1000, "t2");
        check("t2_play_len", 32'(n_play), 32'd501);
        check("t2_done_count", 32'(n_done), 32'd1);
        check("t2_gap_len", 32'(n_gap), 32'(GAP_TICKS));
        check("t2_pend_clear", 32'(last_pend), 32'd0);

        // 3: alarm preempts a playing chime with no gap; chime not replayed.
        alarm_req = 0; cycle();
        clr_stats();
        chime_req = 1; cycle(); chime_req = 0;
        wait_play(10, "t3");
        repeat (299) cycle();
        alarm_req = 1; cycle();
        n = 0;
        do begin cycle(); n++; end while (!(last_play === 1'b1 && last_sel === 2'd1) && n < 10);
        check("t3_switch_latency", 32'(n), 32'd2);
        k = int'($urandom_range(50, 400));
        repeat (k) cycle();
        ack = 1; cycle(); ack = 0;
        wait_idle(1000, "t3");
        check("t3_chime_len", 32'(n_sel[3]), 32'd302);
        check("t3_alarm_len", 32'(n_sel[1]), 32'(k + 2));
        check("t3_done_count", 32'(n_done), 32'd2);
        check("t3_single_gap", 32'(n_gap), 32'(GAP_TICKS));

        // 4: simultaneous edges served alarm, timer, chime in turn.
        alarm_req = 0; cycle();
        clr_stats();
        alarm_req = 1; timer_req = 1; chime_req = 1; cycle();
        alarm_req = 0; timer_req = 0; chime_req = 0;
        cycle();
        check("t4_pend_all", 32'(last_pend), 32'b111);
        cycle();
        check("t4_pend_after_alarm", 32'(last_pend), 32'b110);
        k = int'($urandom_range(100, 300));
        repeat (k) cycle();
        ack = 1; cycle(); ack = 0;
        wait_idle(15000, "t4");
        check("t4_alarm_len", 32'(n_sel[1]), 32'(k + 2));
        check("t4_timer_len", 32'(n_sel[2]), 32'(TIMER_DUR));
        check("t4_chime_len", 32'(n_sel[3]), 32'(CHIME_DUR));
        check("t4_done_count", 32'(n_done), 32'd3);
        check("t4_gap_len", 32'(n_gap), 32'(3 * GAP_TICKS));

        // Random phase: sparse toggles of every input, model-checked each cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) alarm_req = ~alarm_req;
            if ($urandom_range(0, 399) == 0) timer_req = ~timer_req;
            if ($urandom_range(0, 149) == 0) chime_req = ~chime_req;
            if ($urandom_range(0, 499) == 0) chime_en  = ~chime_en;
            if ($urandom_range(0, 59)  == 0) ack       = ~ack;
            cycle();
        end

        // 6: asynchronous reset clears outputs at once; held alarm does not restart.
        rst = 1;
        #1;
        check("t6_async_clear_a", 32'({play, song_sel, busy, pend, done}), 32'd0);
        model_reset();
        alarm_req = 0; timer_req = 0; chime_req = 0; ack = 0; chime_en = 1;
        cycle(); cycle();
        rst = 0;
        repeat (3) cycle();
        alarm_req = 1;
        wait_play(10, "t6");
        repeat (20) cycle();
        rst = 1;
        #1;
        check("t6_async_clear_b", 32'({play, song_sel, busy, pend, done}), 32'd0);
        model_reset();
        cycle(); cycle();
        rst = 0;
        clr_stats();
        repeat (50) cycle();
        check("t6_no_restart", 32'(n_play), 32'd0);
        check("t6_pend_zero", 32'(last_pend), 32'd0);

        // 5: chime ignored when disabled; unacked alarm stops after ALARM_MAX.
        chime_en = 0;
        clr_stats();
        chime_req = 1; cycle(); chime_req = 0;
        repeat (20) cycle();
        check("t5_chime_ignored_play", 32'(n_play), 32'd0);
        check("t5_chime_ignored_pend", 32'(last_pend), 32'd0);
        alarm_req = 0; cycle();
        clr_stats();
        alarm_req = 1; cycle();
        wait_idle(61000, "t5");
        check("t5_alarm_len", 32'(n_play), 32'(ALARM_MAX));
        check("t5_sel_alarm", 32'(n_sel[1]), 32'(ALARM_MAX));
        check("t5_done_count", 32'(n_done), 32'd1);
        check("t5_gap_len", 32'(n_gap), 32'(GAP_TICKS));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
